// File: rtl/arb_pkg.sv
// Shared types and helpers for the weighted round-robin burst arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int N_DEF = 4;
  localparam int IDW   = $clog2(N_DEF);

  function automatic int onehot2idx(input logic [31:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set bit of vec at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int IW = IDW
) (
  input  logic [N-1:0]  vec,
  input  logic [IW-1:0] ptr,
  output logic          hit,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);

  // Scan from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    onehot = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (vec[(int'(ptr) + k) % N]) onehot = N'(1) << ((int'(ptr) + k) % N);
    end
    hit = |vec;
    idx = IW'(onehot2idx(32'(onehot)));
  end

endmodule

// File: rtl/wrr_burst_arb.sv
// Weighted round-robin arbiter: winner holds the resource for a whole burst, up to wgt bursts per round.
// Latency: grant one cycle after request sampled in IDLE; one idle bubble between transactions.
// Backpressure: ready low stalls the owner's beats and holds the grant indefinitely.
module wrr_burst_arb
  import arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int WW      = 4,
  parameter int DEF_WGT = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         req_last,
  input  logic                 ready,
  output logic [N-1:0]         gnt,
  output logic                 gnt_vld,
  output logic [$clog2(N)-1:0] gnt_id,
  input  logic                 cfg_we,
  input  logic [$clog2(N)-1:0] cfg_idx,
  input  logic [WW-1:0]        cfg_wgt
);

  localparam int IW = $clog2(N);

  state_t        state, state_nx;
  logic [IW-1:0] ptr, ptr_nx, id_nx;
  logic [N-1:0]  gnt_nx;
  logic [WW-1:0] wgt  [N];
  logic [WW-1:0] cred [N];
  logic [N-1:0]  el_c, el_w;
  logic          c_hit, w_hit;
  logic [IW-1:0] c_idx, w_idx;
  logic [N-1:0]  c_oh, w_oh;
  logic          reload, dec, txn_end;
  logic [WW-1:0] cred_dec;

  // A zero weight blocks a requester even if it still holds stale credit.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      el_w[i] = req[i] && (wgt[i] != '0);
      el_c[i] = el_w[i] && (cred[i] != '0);
    end
  end

  rr_pick #(.N(N), .IW(IW)) u_pick_cred (
    .vec(el_c), .ptr(ptr), .hit(c_hit), .idx(c_idx), .onehot(c_oh)
  );

  rr_pick #(.N(N), .IW(IW)) u_pick_wgt (
    .vec(el_w), .ptr(ptr), .hit(w_hit), .idx(w_idx), .onehot(w_oh)
  );

  assign txn_end  = !req[gnt_id] || (ready && req_last[gnt_id]);
  assign cred_dec = (cred[gnt_id] == '0) ? '0 : cred[gnt_id] - 1'b1;

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    id_nx    = gnt_id;
    ptr_nx   = ptr;
    reload   = 1'b0;
    dec      = 1'b0;
    case (state)
      IDLE: begin
        if (c_hit) begin
          state_nx = BUSY;
          gnt_nx   = c_oh;
          id_nx    = c_idx;
        end else if (w_hit) begin
          reload   = 1'b1;
          state_nx = BUSY;
          gnt_nx   = w_oh;
          id_nx    = w_idx;
        end
      end
      BUSY: begin
        if (txn_end) begin
          state_nx = IDLE;
          gnt_nx   = '0;
          dec      = 1'b1;
          if (cred_dec != '0) ptr_nx = gnt_id;
          else if (gnt_id == IW'(N - 1)) ptr_nx = '0;
          else ptr_nx = gnt_id + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gnt     <= '0;
      gnt_vld <= 1'b0;
      gnt_id  <= '0;
      ptr     <= '0;
    end else begin
      gnt     <= gnt_nx;
      gnt_vld <= |gnt_nx;
      gnt_id  <= id_nx;
      ptr     <= ptr_nx;
    end
  end

  // Reload reads wgt before any same-cycle cfg write lands.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) begin
        wgt[i]  <= WW'(DEF_WGT);
        cred[i] <= WW'(DEF_WGT);
      end
    end else begin
      if (reload) begin
        for (int i = 0; i < N; i++) cred[i] <= wgt[i];
      end
      if (dec) cred[gnt_id] <= cred_dec;
      if (cfg_we && (int'(cfg_idx) < N)) wgt[cfg_idx] <= cfg_wgt;
    end
  end

endmodule

// File: tb/tb_wrr_burst_arb.sv
// Directed bench for wrr_burst_arb: grant order, bursts, aborts, weights, async reset.
module tb_wrr_burst_arb;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] req, req_last;
  logic       ready;
  logic [3:0] gnt;
  logic       gnt_vld;
  logic [1:0] gnt_id;
  logic       cfg_we;
  logic [1:0] cfg_idx;
  logic [3:0] cfg_wgt;

  int n_cmp = 0;
  int n_err = 0;

  wrr_burst_arb #(.N(4), .WW(4), .DEF_WGT(1)) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_last(req_last), .ready(ready),
    .gnt(gnt), .gnt_vld(gnt_vld), .gnt_id(gnt_id),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_wgt(cfg_wgt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_gnt(input string tag, input logic [3:0] g, input logic [1:0] id);
    chk({tag, "_gnt"}, 32'(gnt), 32'(g));
    chk({tag, "_vld"}, 32'(gnt_vld), 32'(|g));
    if (g != 4'b0000) chk({tag, "_id"}, 32'(gnt_id), 32'(id));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req  = 4'b0000;
    rstn = 1'b0;
    #1;
    exp_gnt("rst", 4'b0000, 2'd0);
    #1;
    rstn = 1'b1;
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [3:0] w);
    cfg_we  = 1'b1;
    cfg_idx = idx;
    cfg_wgt = w;
    tick();
    cfg_we  = 1'b0;
  endtask

  int ord1[5]  = '{0, 1, 2, 3, 0};
  int ord2[10] = '{0, 1, 2, 3, 0, 0, 0, 1, 2, 3};

  initial begin
    rstn = 1'b0; req = '0; req_last = '0; ready = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_wgt = '0;
    #7;
    exp_gnt("reset", 4'b0000, 2'd0);
    chk("reset_id", 32'(gnt_id), 32'd0);
    rstn = 1'b1;

    // 1: plain round robin, single-beat transactions
    req = 4'b1111; req_last = 4'b1111; ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_gnt("t1_grant", 4'(1 << ord1[i]), 2'(ord1[i]));
      tick();
      exp_gnt("t1_idle", 4'b0000, 2'd0);
    end
    req = 4'b0000;

    // 2: req0 weight 3; live credit stays 1 until the first reload
    do_reset();
    cfg(2'd0, 4'd3);
    req = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick();
      exp_gnt("t2_grant", 4'(1 << ord2[i]), 2'(ord2[i]));
      tick();
      exp_gnt("t2_idle", 4'b0000, 2'd0);
    end
    req = 4'b0000;

    // 3: 4-beat burst with ready toggling; req1 waits
    do_reset();
    req = 4'b0011; req_last = 4'b0000; ready = 1'b1;
    tick();
    exp_gnt("t3_grant0", 4'b0001, 2'd0);
    for (int k = 0; k < 7; k++) begin
      ready    = (k % 2 == 0);
      req_last = (k == 6) ? 4'b0001 : 4'b0000;
      tick();
      if (k < 6) exp_gnt("t3_hold", 4'b0001, 2'd0);
      else       exp_gnt("t3_end", 4'b0000, 2'd0);
    end
    req_last = 4'b0011; ready = 1'b1;
    tick();
    exp_gnt("t3_grant1", 4'b0010, 2'd1);
    tick();
    exp_gnt("t3_idle", 4'b0000, 2'd0);
    req = 4'b0000;

    // 4: abort mid-burst decrements credit and moves priority on
    do_reset();
    req = 4'b0011; req_last = 4'b0000; ready = 1'b1;
    tick();
    exp_gnt("t4_grant0", 4'b0001, 2'd0);
    tick();
    exp_gnt("t4_beat", 4'b0001, 2'd0);
    req = 4'b0010;
    tick();
    exp_gnt("t4_abort", 4'b0000, 2'd0);
    req = 4'b0011;
    tick();
    exp_gnt("t4_grant1", 4'b0010, 2'd1);
    req_last = 4'b0010;
    tick();
    exp_gnt("t4_end1", 4'b0000, 2'd0);
    tick();
    exp_gnt("t4_reload", 4'b0001, 2'd0);
    req = 4'b0000;
    tick();
    exp_gnt("t4_abort0", 4'b0000, 2'd0);

    // 5: zero weight blocks requester 2 until restored
    do_reset();
    cfg(2'd2, 4'd0);
    req = 4'b0100; req_last = 4'b1111; ready = 1'b1;
    tick();
    exp_gnt("t5_zero_a", 4'b0000, 2'd0);
    tick();
    exp_gnt("t5_zero_b", 4'b0000, 2'd0);
    cfg(2'd2, 4'd2);
    exp_gnt("t5_wr_edge", 4'b0000, 2'd0);
    tick();
    exp_gnt("t5_grant", 4'b0100, 2'd2);
    tick();
    exp_gnt("t5_idle", 4'b0000, 2'd0);
    tick();
    exp_gnt("t5_grant_rl", 4'b0100, 2'd2);

    // 6: ready low holds BUSY; async reset drops grant at once
    ready = 1'b0;
    tick();
    exp_gnt("t6_hold_a", 4'b0100, 2'd2);
    tick();
    exp_gnt("t6_hold_b", 4'b0100, 2'd2);
    #2;
    rstn = 1'b0;
    #1;
    exp_gnt("t6_async", 4'b0000, 2'd0);
    chk("t6_async_id", 32'(gnt_id), 32'd0);
    req = 4'b1000; ready = 1'b1;
    #2;
    rstn = 1'b1;
    tick();
    exp_gnt("t6_grant3", 4'b1000, 2'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
